lat_tester_ctrl: RTL
====================

// Module: lat_tester_ctrl
// PURPOSE
//  Sequencer for the latency-test pattern in the test video generator. On a trigger it
//  arms, starts the white test box on a frame boundary by driving lt_active/lt_mode, and
//  times (in us) until the photodiode sensor sees light. It then blanks the box and
//  enforces a cool-down before the next measurement. Sits beside the video generator.
//  Its result goes to the status/display logic.
// PARAMETERS
//  PRESCALE        27      clk27 cycles per latency count (1 us at 27 MHz)
//  TIMEOUT_US      50000   lat_cnt value at which a measurement aborts as timeout
//  DEBOUNCE        8       sensor must be stable high this many clk27 cycles to register
//  COOLDOWN_FRAMES 4       vsync falling edges with sensor low required before IDLE
// PORTS
//  clk27         in   1   27 MHz pixel clock
//  reset_n       in   1   asynchronous, active-low reset
//  trigger       in   1   start request, clk27-synchronous level; rising edge acts
//  mode_sel      in   2   box position: 1 top-left, 2 center, 3 bottom-right; 0 invalid
//  vsync_in      in   1   VSYNC from video generator, negative polarity, clk27 domain
//  sensor_in     in   1   photodiode comparator, asynchronous, high = light detected
//  lt_active     out  1   to video generator: latency-test pattern enabled
//  lt_mode       out  2   to video generator: box position (mode latched at trigger)
//  busy          out  1   high whenever state != IDLE
//  result_valid  out  1   high from measurement end until next accepted trigger
//  timeout       out  1   qualifies result_valid: measurement hit TIMEOUT_US
//  result_us     out  16  measured latency in PRESCALE units; 16'hFFFF on timeout
// BEHAVIOUR
//  Reset: state=IDLE; lt_active=0, lt_mode=0, busy=0, result_valid=0, timeout=0,
//   result_us=0; all counters, synchronisers and edge registers cleared.
//  Inputs: sensor_in -> 2-FF sync -> debounce counter; sens_hi=1 after DEBOUNCE
//   consecutive high samples, sens_hi=0 on first low sample.
//  Inputs: trigger and vsync_in are registered once for edge detection.
//   vs_fall = prev 1 & cur 0.
//  IDLE: trigger rising edge with mode_sel!=0 -> latch mode, clear result_valid/timeout,
//   go ARM. mode_sel==0 edge ignored. lt_active=0.
//  ARM: on vs_fall with sens_hi=0: same cycle registers lt_active<=1, lt_mode<=latched,
//   prescaler<=0, lat_cnt<=0 -> MEASURE. vs_fall with sens_hi=1: stay ARM.
//  MEASURE: prescaler counts 0..PRESCALE-1; at PRESCALE-1 wraps and lat_cnt++.
//   sens_hi=1 (checked before timeout): result_us<=lat_cnt, result_valid<=1 -> COOL.
//   lat_cnt==TIMEOUT_US: result_us<=16'hFFFF, timeout<=1, result_valid<=1 -> COOL.
//  COOL: lt_active<=0, lt_mode<=0 on entry. frame counter counts vs_fall with sens_hi=0.
//   Any sens_hi=1 clears it. Reaching COOLDOWN_FRAMES -> IDLE.
//  Triggers outside IDLE are ignored (not queued).
//  lat_cnt is 16 bits; never exceeds TIMEOUT_US, so no wrap.
//  Latency: the count includes the remainder of the vsync pulse, back porch and scan-out.
//   No compensation in this block.
//  Reset mid-operation: immediate return to reset values; lt_active drops asynchronously.
//  busy is registered with state (asserts cycle after accepted trigger).
// TESTING
//  1 trigger mode 1, sensor high 2700 cycles after first vs_fall -> lt_mode=1, result_us=100, timeout=0.
//  2 trigger mode 2, sensor never high -> at lat_cnt 50000: result_us=16'hFFFF, timeout=1, lt_active=0.
//  3 sensor held high in ARM -> lt_active stays 0; release -> pattern starts on next vs_fall.
//  4 sensor glitch 5 cycles in MEASURE -> ignored; 8-cycle pulse -> registered, result latched.
//  5 trigger during MEASURE/COOL and mode_sel=0 in IDLE -> no state change; busy drops after 4 clean frames.
//  6 reset_n low mid-MEASURE -> all outputs 0 immediately; next trigger measures normally.

Source files
------------

// File: rtl/lat_tester_ctrl_if.sv
// ---------------------------------------------------------------------------
// lat_tester_ctrl_if
// Bundles the signals between the latency-test sequencer and its surroundings.
// The video generator supplies VSYNC and reads lt_active/lt_mode. The
// photodiode front end supplies sensor_in. The status/display logic supplies
// trigger/mode_sel and reads the result.
//   trigger       start request level; the rising edge acts
//   mode_sel[1:0] requested box position (0 is invalid)
//   vsync_in      negative-polarity VSYNC, clk27 domain
//   sensor_in     asynchronous photodiode comparator, high = light
//   lt_active     latency-test pattern enable
//   lt_mode[1:0]  box position shown while the pattern is enabled
//   busy          sequencer is not idle
//   result_valid  a result is held in result_us
//   timeout       the held result is a timeout
//   result_us     measured latency in prescaler units
// Modports: master = driving side (controller/bench), slave = the sequencer.
// ---------------------------------------------------------------------------
interface lat_tester_ctrl_if;
    logic        trigger;
    logic [1:0]  mode_sel;
    logic        vsync_in;
    logic        sensor_in;
    logic        lt_active;
    logic [1:0]  lt_mode;
    logic        busy;
    logic        result_valid;
    logic        timeout;
    logic [15:0] result_us;

    modport master (
        output trigger, mode_sel, vsync_in, sensor_in,
        input  lt_active, lt_mode, busy, result_valid, timeout, result_us
    );

    modport slave (
        input  trigger, mode_sel, vsync_in, sensor_in,
        output lt_active, lt_mode, busy, result_valid, timeout, result_us
    );
endinterface

// File: rtl/lat_tester_ctrl.sv
// ---------------------------------------------------------------------------
// lat_tester_ctrl
// Sequencer for the display latency test. A trigger arms it. On the next
// VSYNC falling edge it enables the white test box. It then counts time in
// PRESCALE-cycle units until the debounced photodiode reports light. The box
// is then blanked, and the sequencer waits COOLDOWN_FRAMES dark frames before
// it accepts another trigger.
// Ports:
//   clk27    27 MHz pixel clock
//   reset_n  asynchronous active-low reset
//   lt_bus   lat_tester_ctrl_if.slave (trigger/mode/vsync/sensor in,
//            pattern control and result out)
// The measured count includes the rest of the VSYNC pulse, the back porch
// and the scan-out down to the box. This block applies no compensation.
// ---------------------------------------------------------------------------
module lat_tester_ctrl #(
    parameter int PRESCALE        = 27,
    parameter int TIMEOUT_US      = 50000,
    parameter int DEBOUNCE        = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic          clk27,
    input  logic          reset_n,
    lat_tester_ctrl_if.slave lt_bus
);

    localparam int PRESC_W = $clog2(PRESCALE + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int FRAME_W = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(PRESCALE - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DEBOUNCE - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(COOLDOWN_FRAMES - 1);
    localparam logic [15:0]        TIMEOUT_CNT = 16'(TIMEOUT_US);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_COOL    = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    logic               sens_meta_r;
    logic               sens_sync_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic               sens_hi_r;
    logic               trig_prev_r;
    logic               vs_prev_r;
    logic [1:0]         mode_lat_r;
    logic [PRESC_W-1:0] presc_r;
    logic [15:0]        lat_cnt_r;
    logic [FRAME_W-1:0] frame_cnt_r;

    logic               lt_active_r;
    logic [1:0]         lt_mode_r;
    logic               busy_r;
    logic               result_valid_r;
    logic               timeout_r;
    logic [15:0]        result_us_r;

    logic               trig_rise_s;
    logic               vs_fall_s;
    logic               accept_s;
    logic               start_s;
    logic               hit_s;
    logic               to_s;

    assign trig_rise_s = lt_bus.trigger & ~trig_prev_r;
    assign vs_fall_s   = vs_prev_r & ~lt_bus.vsync_in;

    // Synchronise the photodiode, then require DEBOUNCE consecutive high samples
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sens_meta_r <= 1'b0;
            sens_sync_r <= 1'b0;
            deb_cnt_r   <= {DEB_W{1'b0}};
            sens_hi_r   <= 1'b0;
        end else begin
            sens_meta_r <= lt_bus.sensor_in;
            sens_sync_r <= sens_meta_r;
            if (!sens_sync_r) begin
                deb_cnt_r <= {DEB_W{1'b0}};
                sens_hi_r <= 1'b0;
            end else if (deb_cnt_r == DEB_LAST) begin
                // The counter saturates here, so a long high stays registered
                deb_cnt_r <= deb_cnt_r;
                sens_hi_r <= 1'b1;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                sens_hi_r <= sens_hi_r;
            end
        end
    end

    // Previous-cycle copies of trigger and VSYNC for edge detection
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            trig_prev_r <= 1'b0;
            vs_prev_r   <= 1'b0;
        end else begin
            trig_prev_r <= lt_bus.trigger;
            vs_prev_r   <= lt_bus.vsync_in;
        end
    end

    // Next-state decode and single-cycle action strobes
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        start_s  = 1'b0;
        hit_s    = 1'b0;
        to_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_rise_s && (lt_bus.mode_sel != 2'd0)) begin
                    accept_s = 1'b1;
                    state_s  = ST_ARM;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Do not start while the sensor already sees light
                if (vs_fall_s && !sens_hi_r) begin
                    start_s = 1'b1;
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_ARM;
                end
            end
            ST_MEASURE: begin
                // Detection wins over a timeout in the same cycle
                if (sens_hi_r) begin
                    hit_s   = 1'b1;
                    state_s = ST_COOL;
                end else if (lat_cnt_r == TIMEOUT_CNT) begin
                    to_s    = 1'b1;
                    state_s = ST_COOL;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_COOL: begin
                if (!sens_hi_r && vs_fall_s && (frame_cnt_r == FRAME_LAST)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_COOL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; busy follows the registered state
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Microsecond prescaler and latency counter
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            presc_r   <= {PRESC_W{1'b0}};
            lat_cnt_r <= 16'd0;
        end else if (start_s) begin
            presc_r   <= {PRESC_W{1'b0}};
            lat_cnt_r <= 16'd0;
        end else if ((state_r == ST_MEASURE) && !hit_s && !to_s) begin
            if (presc_r == PRESC_LAST) begin
                presc_r   <= {PRESC_W{1'b0}};
                lat_cnt_r <= lat_cnt_r + 16'd1;
            end else begin
                presc_r   <= presc_r + PRESC_W'(1);
                lat_cnt_r <= lat_cnt_r;
            end
        end else begin
            presc_r   <= presc_r;
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // Cool-down frame counter: dark VSYNC falls only; any light restarts it
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else if ((state_r != ST_COOL) || sens_hi_r) begin
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else if (vs_fall_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Mode latch, pattern control and result registers
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            mode_lat_r     <= 2'd0;
            lt_active_r    <= 1'b0;
            lt_mode_r      <= 2'd0;
            result_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            result_us_r    <= 16'd0;
        end else if (accept_s) begin
            mode_lat_r     <= lt_bus.mode_sel;
            result_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else if (start_s) begin
            lt_active_r    <= 1'b1;
            lt_mode_r      <= mode_lat_r;
        end else if (hit_s) begin
            lt_active_r    <= 1'b0;
            lt_mode_r      <= 2'd0;
            result_us_r    <= lat_cnt_r;
            result_valid_r <= 1'b1;
        end else if (to_s) begin
            lt_active_r    <= 1'b0;
            lt_mode_r      <= 2'd0;
            result_us_r    <= 16'hFFFF;
            timeout_r      <= 1'b1;
            result_valid_r <= 1'b1;
        end else begin
            mode_lat_r     <= mode_lat_r;
            lt_active_r    <= lt_active_r;
            lt_mode_r      <= lt_mode_r;
            result_valid_r <= result_valid_r;
            timeout_r      <= timeout_r;
            result_us_r    <= result_us_r;
        end
    end

    assign lt_bus.lt_active    = lt_active_r;
    assign lt_bus.lt_mode      = lt_mode_r;
    assign lt_bus.busy         = busy_r;
    assign lt_bus.result_valid = result_valid_r;
    assign lt_bus.timeout      = timeout_r;
    assign lt_bus.result_us    = result_us_r;

endmodule
